// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID register for a single-outstanding instruction memory
// Purpose: holds PCF, issues one fetch at a time, buffers a response that arrives while ID
//   is stalled, squashes wrong-path fetches on redirect, inserts bubbles when idle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   StallF, StallD, FlushD          hazard unit controls
//   PcSrcE, PcTargetE               redirect from EX (target word-aligned here)
//   imem_req, imem_addr, imem_gnt   fetch request channel
//   imem_rvalid, imem_rdata         in-order fetch response channel
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register outputs
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PcSrcE,
  input  logic [XLEN-1:0] PcTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [31:0]     buf_q, buf_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] pcf_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            word_rdy;
  logic [31:0]     word;
  logic            deliver;

  // Wraps modulo 2^XLEN by construction.
  assign pcf_plus4   = pcf_q + {{(XLEN-3){1'b0}}, 3'd4};
  assign redirect_pc = PcTargetE & ~{{(XLEN-2){1'b0}}, 2'b11};

  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    buf_d    = buf_q;
    instr_d  = instr_q;
    pcd_d    = pcd_q;
    pcp4_d   = pcp4_q;
    valid_d  = valid_q;
    imem_req = 1'b0;
    word_rdy = 1'b0;
    word     = imem_rdata;
    deliver  = 1'b0;

    // rvalid outside WAIT/DROP is a protocol error and simply ignored.
    case (state_q)
      S_FETCH: begin
        imem_req = rst_n && !StallF && !PcSrcE;
        if (imem_req && imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) word_rdy = 1'b1;
      end
      S_HOLD: begin
        word_rdy = 1'b1;
        word     = buf_q;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_FETCH;
      end
      default: ;
    endcase

    deliver = word_rdy && !PcSrcE && !StallD && !FlushD;

    if (deliver) begin
      instr_d = word;
      pcd_d   = pcf_q;
      pcp4_d  = pcf_plus4;
      valid_d = 1'b1;
      pcf_d   = pcf_plus4;
      state_d = S_FETCH;
    end else if (word_rdy && !PcSrcE) begin
      // A ready word blocked by StallD or FlushD is parked so it is not lost.
      buf_d   = word;
      state_d = S_HOLD;
    end

    // Bubble: PCD/PCPlus4D keep their last values.
    if (FlushD || (!StallD && !deliver)) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    // A request still in flight must be drained before the new path can fetch.
    if (PcSrcE) begin
      pcf_d = redirect_pc;
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) state_d = S_DROP;
      else                                                          state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pcf_q   <= RESET_PC;
      buf_q   <= '0;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr = pcf_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcp4_q;
  assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PcSrcE = 1'b0;
  logic [31:0] PcTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage #(.XLEN(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PcSrcE(PcSrcE), .PcTargetE(PcTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_deliv  = 0;

  // Memory-side model: one fetch in flight, the program counter the fetcher should use next.
  logic [31:0] next_pc = RST_PC;
  bit          outstanding = 0;
  bit          out_squashed = 0;
  logic [31:0] out_addr = '0;
  int          lat_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0093};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  // Observe request acceptance during the cycle (inputs stable).
  task automatic accept_step();
    if (rst_n && imem_req && imem_gnt) begin
      chk("fetch_addr", imem_addr, next_pc);
      chk("single_outstanding", {31'd0, outstanding}, 32'd0);
      outstanding  = 1;
      out_addr     = next_pc;
      out_squashed = 0;
      lat_cnt      = $urandom_range(0, 2);
    end
  endtask

  task automatic drive_step(input bit quiet);
    bit   resp;
    exp_t e;
    int   sel;
    resp        = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (outstanding) begin
      if (lat_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(out_addr);
        outstanding = 0;
        resp        = 1;
      end else begin
        lat_cnt--;
      end
    end
    StallF   = quiet ? 1'b0 : ($urandom_range(0, 4) == 0);
    StallD   = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
    FlushD   = quiet ? 1'b0 : ($urandom_range(0, 9) == 0);
    PcSrcE   = quiet ? 1'b0 : ($urandom_range(0, 11) == 0);
    imem_gnt = ($urandom_range(0, 3) != 0);
    sel = $urandom_range(0, 3);
    if (sel == 0)      PcTargetE = $urandom_range(32'hFFFF_FFFF, 32'hFFFF_FFF0);
    else if (sel == 1) PcTargetE = 32'h0000_0103;
    else               PcTargetE = $urandom_range(0, 32'h0000_FFFF);

    if (resp && !out_squashed && !PcSrcE) begin
      e.pc    = out_addr;
      e.instr = mem_word(out_addr);
      exp_q.push_back(e);
      next_pc = out_addr + 32'd4;
    end
    if (PcSrcE) begin
      exp_q.delete();
      next_pc      = PcTargetE & 32'hFFFF_FFFC;
      out_squashed = 1;
    end
  endtask

  // Monitor: expected IF/ID contents, checked every cycle, decided from the previous cycle.
  logic [31:0] m_instr = NOP, m_pc = '0, m_pcp4 = '0;
  logic        m_valid = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_instr = NOP; m_pc = '0; m_pcp4 = '0; m_valid = 1'b0;
        chk("reset_req", {31'd0, imem_req}, 32'd0);
      end
      chk("InstrD", InstrD, m_instr);
      chk("PCD", PCD, m_pc);
      chk("PCPlus4D", PCPlus4D, m_pcp4);
      chk("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
      if (rst_n) begin
        if (FlushD) begin
          m_instr = NOP; m_valid = 1'b0;
        end else if (StallD) begin
          // IF/ID holds
        end else if (!PcSrcE && exp_q.size() > 0) begin
          e       = exp_q.pop_front();
          m_instr = e.instr;
          m_pc    = e.pc;
          m_pcp4  = e.pc + 32'd4;
          m_valid = 1'b1;
          n_deliv++;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
    end
  end

  bit reset_done = 0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      accept_step();
      @(posedge clk);
      #1;
      if (!reset_done && cyc >= 2000 && outstanding && !out_squashed && lat_cnt > 0) begin
        // Asynchronous reset while a fetch is in flight.
        reset_done  = 1;
        imem_rvalid = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PcSrcE = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_InstrD", InstrD, NOP);
        chk("async_ValidD", {31'd0, ValidD}, 32'd0);
        chk("async_PCD", PCD, 32'd0);
        chk("async_PCPlus4D", PCPlus4D, 32'd0);
        chk("async_req", {31'd0, imem_req}, 32'd0);
        exp_q.delete();
        outstanding = 0;
        next_pc     = RST_PC;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        continue;
      end
      drive_step(cyc < 20 || cyc >= 3960);
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("async_reset_exercised", {31'd0, reset_done}, 32'd1);
    chk("progress", {31'd0, (n_deliv > 100)}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
